serial_word_comparator: RTL and testbench
=========================================

# serial_word_comparator

Sequencer that compares two wide unsigned words using one shared 4-bit magnitude-comparator slice, one nibble per cycle, most-significant nibble first, stopping at the first differing nibble. It sits between a requester issuing compare jobs and a single instance of the team's 4-bit comparator (G/L/E outputs). It drives that comparator's operands, interprets its flags and returns a registered greater/less/equal result with a done pulse.

## Interface
- NIBBLES, 4, number of 4-bit nibbles per operand (≥2); word width W = 4*NIBBLES
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a compare; sampled only in IDLE
- abort  in  1  cancel an in-progress compare
- a  in  W  operand A, sampled on accepted start
- b  in  W  operand B, sampled on accepted start
- cmp_p  out  4  operand P to the shared 4-bit comparator
- cmp_q  out  4  operand Q to the shared 4-bit comparator
- cmp_g  in  1  comparator P>Q flag (combinational return, same cycle)
- cmp_l  in  1  comparator P<Q flag
- cmp_e  in  1  comparator P==Q flag
- busy  out  1  high in COMPARE and DONE
- done  out  1  one-cycle pulse, result valid
- gt, lt, eq  out  1 each  registered result, A>B / A<B / A==B
- nib_cnt  out  $clog2(NIBBLES+1)  nibbles examined for last result
- err  out  1  comparator returned inconsistent flags

## Operation
- States: IDLE, COMPARE, DONE.
- IDLE: start=1 latches a, b into a_r, b_r; idx ← NIBBLES-1; cnt ← 0; → COMPARE. start=0 stays.
- cmp_p = a_r[4*idx+3:4*idx], cmp_q = b_r[4*idx+3:4*idx] whenever in COMPARE; 0 in IDLE/DONE.
- COMPARE, each cycle, flags sampled at clock edge; cnt+1 recorded:
  - exactly one of cmp_g/cmp_l/cmp_e high required; otherwise err←1, gt/lt/eq←0, → DONE.
  - cmp_g: gt←1, lt←0, eq←0, → DONE.
  - cmp_l: lt←1, gt←0, eq←0, → DONE.
  - cmp_e and idx==0: eq←1, gt←0, lt←0, → DONE.
  - cmp_e and idx>0: idx←idx-1, stay.
- DONE: done=1 for this one cycle; → IDLE unconditionally. start during DONE ignored.
- gt/lt/eq/nib_cnt/err update only on the transition into DONE; held until next update. err cleared on each accepted start.
- abort=1 in COMPARE: → IDLE next edge, no done pulse, gt/lt/eq/nib_cnt/err unchanged (err keeps value cleared at start). abort in IDLE/DONE ignored. abort has priority over a result in the same cycle.
- start while busy: ignored, not queued.
- Simultaneous start and abort in IDLE: start accepted.

## Timing
- Reset (rst_n=0, async): state IDLE; busy, done, gt, lt, eq, err = 0; nib_cnt = 0; cmp_p, cmp_q = 0; a_r, b_r, idx cleared. Reset mid-compare discards job, no done.
- Accepted start at edge E0 → COMPARE for k cycles (k = nibbles examined, 1..NIBBLES) → done high in cycle after edge E0+k. Latency start-edge to done = k+1 cycles; max NIBBLES+1.
- Throughput: one job per k+2 cycles (DONE → IDLE → start).
- busy rises the cycle after accepted start; falls with DONE → IDLE.
- Comparator path is combinational within one cycle: register → cmp_p/q → external comparator → flags → next-state.

## Test plan
- NIBBLES=4, a=16'h1234, b=16'h1234 → eq=1, gt=lt=0, nib_cnt=4, done exactly 5 cycles after start edge, one cycle wide.
- a=16'h9000, b=16'h1FFF → gt=1, nib_cnt=1, done 2 cycles after start; a=16'h0005, b=16'h0006 → lt=1, nib_cnt=4, done at 5.
- a=16'hAB30, b=16'hAB40 → lt=1, nib_cnt=3; start pulsed in each busy cycle → ignored, exactly one done, next job accepted only after return to IDLE.
- Start a=16'h1111, b=16'h1112; abort in 2nd COMPARE cycle → no done, IDLE next cycle, prior result outputs unchanged; following job completes normally.
- Faulty comparator model forcing cmp_g=cmp_l=1 on nibble 2 → err=1, gt=lt=eq=0, nib_cnt=2, done pulse; next clean job clears err.
- rst_n low asynchronously mid-COMPARE (between edges) → all outputs 0 immediately, no done after release; randomized 1000 word pairs vs. reference compare, including all-zero and all-F operands.

Source files
------------

// File: rtl/serial_word_comparator_if.sv
// Job request/result bundle between a requester and the serial word comparator.
// The requester drives start/abort/operands; the comparator returns status and a registered verdict.
interface serial_word_comparator_if #(
  parameter int NIBBLES = 4
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  logic          start;
  logic          abort;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic          gt;
  logic          lt;
  logic          eq;
  logic          err;
  logic [CW-1:0] nib_cnt;

  modport master (
    output start, abort, a, b,
    input  busy, done, gt, lt, eq, err, nib_cnt
  );

  modport slave (
    input  start, abort, a, b,
    output busy, done, gt, lt, eq, err, nib_cnt
  );
endinterface

// File: rtl/serial_word_comparator.sv
// Compares two words MS nibble first through one shared 4-bit comparator; done k+1 edges after start (k = nibbles examined).
// No queueing: start is only taken in IDLE, abort drops the job without a done pulse.
module serial_word_comparator #(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_word_comparator_if.slave   job,
  output logic [3:0]                cmp_p,
  output logic [3:0]                cmp_q,
  input  logic                      cmp_g,
  input  logic                      cmp_l,
  input  logic                      cmp_e
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam int CW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          flags_ok;
  logic          finish;

  assign flags_ok = $onehot({cmp_g, cmp_l, cmp_e});
  assign cnt_inc  = cnt + CW'(1);
  // A bad flag set, any inequality, or equality on the last nibble ends the job.
  assign finish   = (state == COMPARE) && !job.abort &&
                    (!flags_ok || cmp_g || cmp_l || (idx == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job.start) state_nxt = COMPARE;
      COMPARE: begin
        if (job.abort) begin
          state_nxt = IDLE;
        end else if (finish) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    job.busy = (state != IDLE);
    job.done = (state == DONE);
    cmp_p    = 4'h0;
    cmp_q    = 4'h0;
    if (state == COMPARE) begin
      cmp_p = a_r[{idx, 2'b00} +: 4];
      cmp_q = b_r[{idx, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      idx         <= '0;
      cnt         <= '0;
      job.gt      <= 1'b0;
      job.lt      <= 1'b0;
      job.eq      <= 1'b0;
      job.err     <= 1'b0;
      job.nib_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (job.start) begin
            a_r     <= job.a;
            b_r     <= job.b;
            idx     <= IW'(NIBBLES - 1);
            cnt     <= '0;
            job.err <= 1'b0;
          end
        end
        COMPARE: begin
          // Abort leaves the previous verdict untouched.
          if (!job.abort) begin
            cnt <= cnt_inc;
            if (finish) begin
              job.nib_cnt <= cnt_inc;
              job.err     <= !flags_ok;
              job.gt      <= flags_ok & cmp_g;
              job.lt      <= flags_ok & cmp_l;
              job.eq      <= flags_ok & cmp_e;
            end else begin
              idx <= idx - IW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed and random jobs against a behavioural 4-bit comparator with fault injection;
// expected verdicts are queued at start and popped when done is observed.
module tb_serial_word_comparator;
  localparam int NIBBLES = 4;

  typedef struct {
    logic gt;
    logic lt;
    logic eq;
    logic err;
    int   cnt;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_word_comparator_if #(.NIBBLES(NIBBLES)) job ();

  logic [3:0] cmp_p;
  logic [3:0] cmp_q;
  logic       cmp_g;
  logic       cmp_l;
  logic       cmp_e;
  logic       fault_en;
  logic       fault_hit;

  // Faulty slice: nibble pair 2/2 reports both G and L.
  assign fault_hit = fault_en && (cmp_p == 4'h2) && (cmp_q == 4'h2);
  assign cmp_g     = fault_hit | (cmp_p > cmp_q);
  assign cmp_l     = fault_hit | (cmp_p < cmp_q);
  assign cmp_e     = !fault_hit & (cmp_p == cmp_q);

  serial_word_comparator #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .job   (job),
    .cmp_p (cmp_p),
    .cmp_q (cmp_q),
    .cmp_g (cmp_g),
    .cmp_l (cmp_l),
    .cmp_e (cmp_e)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic gt, input logic lt, input logic eq,
                              input logic err, input int cnt);
    exp_t e;
    e.gt  = gt;
    e.lt  = lt;
    e.eq  = eq;
    e.err = err;
    e.cnt = cnt;
    e.lat = cnt + 1;
    return e;
  endfunction

  function automatic exp_t ref_model(input logic [15:0] a, input logic [15:0] b);
    int k;
    k = NIBBLES;
    for (int i = NIBBLES - 1; i >= 0; i--) begin
      if (a[4*i +: 4] != b[4*i +: 4]) begin
        k = NIBBLES - i;
        break;
      end
    end
    return mk(a > b, a < b, a == b, 1'b0, k);
  endfunction

  // Called at a negedge; latency counts negedges from the accept edge until done is seen.
  task automatic run_job(input logic [15:0] a, input logic [15:0] b, input exp_t e, input bit hammer);
    exp_t x;
    int   lat;
    bit   got;
    sb.push_back(e);
    job.a     = a;
    job.b     = b;
    job.start = 1'b1;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (hammer) begin
        job.a = 16'($urandom);
        job.b = 16'($urandom);
      end else begin
        job.start = 1'b0;
      end
      if (lat == 1) check("busy_rise", 32'(job.busy), 32'd1);
      if (job.done) got = 1'b1;
    end
    job.start = 1'b0;
    x = sb.pop_front();
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("latency", 32'(lat), 32'(x.lat));
      check("gt", 32'(job.gt), 32'(x.gt));
      check("lt", 32'(job.lt), 32'(x.lt));
      check("eq", 32'(job.eq), 32'(x.eq));
      check("err", 32'(job.err), 32'(x.err));
      check("nib_cnt", 32'(job.nib_cnt), 32'(x.cnt));
      @(negedge clk);
      check("done_width", 32'(job.done), 32'd0);
      check("idle_after_done", 32'(job.busy), 32'd0);
    end
  endtask

  logic [15:0] ra;
  logic [15:0] rb;

  initial begin
    job.start = 1'b0;
    job.abort = 1'b0;
    job.a     = '0;
    job.b     = '0;
    fault_en  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(job.busy), 32'd0);
    check("rst_done", 32'(job.done), 32'd0);
    check("rst_verdict", 32'({job.gt, job.lt, job.eq, job.err}), 32'd0);
    check("rst_nib_cnt", 32'(job.nib_cnt), 32'd0);
    check("rst_cmp_pq", 32'({cmp_p, cmp_q}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(16'h1234, 16'h1234, mk(0, 0, 1, 0, 4), 1'b0);
    run_job(16'h9000, 16'h1FFF, mk(1, 0, 0, 0, 1), 1'b0);
    run_job(16'h0005, 16'h0006, mk(0, 1, 0, 0, 4), 1'b0);
    // start held high with junk operands through busy and DONE
    run_job(16'hAB30, 16'hAB40, mk(0, 1, 0, 0, 3), 1'b1);

    job.a     = 16'h1111;
    job.b     = 16'h1112;
    job.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    job.start = 1'b0;
    @(negedge clk);
    job.abort = 1'b1;
    @(negedge clk);
    job.abort = 1'b0;
    check("abort_idle", 32'(job.busy), 32'd0);
    check("abort_no_done", 32'(job.done), 32'd0);
    check("abort_keeps_verdict", 32'({job.gt, job.lt, job.eq, job.err}), 32'b0100);
    check("abort_keeps_cnt", 32'(job.nib_cnt), 32'd3);
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet", 32'(job.done), 32'd0);
    end
    run_job(16'h1111, 16'h1112, mk(0, 1, 0, 0, 4), 1'b0);

    fault_en = 1'b1;
    run_job(16'h1234, 16'h1234, mk(0, 0, 0, 1, 2), 1'b0);
    fault_en = 1'b0;
    run_job(16'h5678, 16'h5678, mk(0, 0, 1, 0, 4), 1'b0);

    job.a     = 16'h3456;
    job.b     = 16'h3457;
    job.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    job.start = 1'b0;
    check("cmp_p_first", 32'(cmp_p), 32'h3);
    check("cmp_q_first", 32'(cmp_q), 32'h3);
    @(negedge clk);
    check("cmp_p_second", 32'(cmp_p), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(job.busy), 32'd0);
    check("arst_done", 32'(job.done), 32'd0);
    check("arst_verdict", 32'({job.gt, job.lt, job.eq, job.err}), 32'd0);
    check("arst_nib_cnt", 32'(job.nib_cnt), 32'd0);
    check("arst_cmp_pq", 32'({cmp_p, cmp_q}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("arst_no_done", 32'(job.done), 32'd0);
    end

    run_job(16'h0000, 16'h0000, ref_model(16'h0000, 16'h0000), 1'b0);
    run_job(16'hFFFF, 16'hFFFF, ref_model(16'hFFFF, 16'hFFFF), 1'b0);
    run_job(16'h0000, 16'hFFFF, ref_model(16'h0000, 16'hFFFF), 1'b0);
    run_job(16'hFFFF, 16'h0000, ref_model(16'hFFFF, 16'h0000), 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        2:       rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
        default: rb = {ra[15:8], 8'($urandom)};
      endcase
      run_job(ra, rb, ref_model(ra, rb), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
